// File: rtl/spi_access_arbiter.sv
// spi_access_arbiter: round-robin sharing of one SPI register-access engine
// between NUM_REQ requesters, one transaction in flight, with a timeout watchdog.
module spi_access_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned TO_W        = 13
) (
  input  logic                  clk_100m,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*8-1:0]  req_com,
  input  logic [NUM_REQ*16-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_gnt,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [NUM_REQ-1:0]    req_err,
  output logic [31:0]           req_rdata,
  output logic [7:0]            spi_com,
  output logic [15:0]           spi_addr,
  output logic [31:0]           mosi_data,
  output logic                  spi_run,
  input  logic                  spi_done,
  input  logic [31:0]           miso_data,
  output logic                  busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_nxt;
  logic [TO_W-1:0]    cnt, cnt_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, done_nxt, err_nxt;
  logic [31:0]        rdata_nxt, wdata_nxt;
  logic [7:0]         com_nxt;
  logic [15:0]        addr_nxt;
  logic               run_nxt;

  // arbitration result: first pending requester at or after rr_ptr
  logic               found;
  logic [IDX_W-1:0]   sel;
  logic [7:0]         sel_com;
  logic [15:0]        sel_addr;
  logic [31:0]        sel_wdata;

  // round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int unsigned c;
    c         = 0;
    found     = 1'b0;
    sel       = '0;
    sel_com   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      c = (32'(rr_ptr) + k) % NUM_REQ;
      if (!found && 1'(req >> c)) begin
        found     = 1'b1;
        sel       = IDX_W'(c);
        sel_com   = 8'(req_com >> (c * 8));
        sel_addr  = 16'(req_addr >> (c * 16));
        sel_wdata = 32'(req_wdata >> (c * 32));
      end
    end
  end

  // state register
  always_ff @(posedge clk_100m) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state and next-output decode
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = req_gnt;
    done_nxt  = '0;
    err_nxt   = '0;
    rdata_nxt = req_rdata;
    com_nxt   = spi_com;
    addr_nxt  = spi_addr;
    wdata_nxt = mosi_data;
    run_nxt   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          idx_nxt   = sel;
          com_nxt   = sel_com;
          addr_nxt  = sel_addr;
          wdata_nxt = sel_wdata;
          gnt_nxt   = NUM_REQ'(1) << sel;
          run_nxt   = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // a completion on the timeout cycle still counts as success
        if (spi_done) begin
          rdata_nxt = miso_data;
          done_nxt  = NUM_REQ'(1) << idx;
          state_nxt = S_DONE;
        end else if (cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          rdata_nxt = '0;
          done_nxt  = NUM_REQ'(1) << idx;
          err_nxt   = NUM_REQ'(1) << idx;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + TO_W'(1);
        end
      end
      S_DONE: begin
        gnt_nxt   = '0;
        rr_nxt    = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // registered outputs and datapath
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      idx       <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      req_gnt   <= '0;
      req_done  <= '0;
      req_err   <= '0;
      req_rdata <= '0;
      spi_com   <= '0;
      spi_addr  <= '0;
      mosi_data <= '0;
      spi_run   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      idx       <= idx_nxt;
      rr_ptr    <= rr_nxt;
      cnt       <= cnt_nxt;
      req_gnt   <= gnt_nxt;
      req_done  <= done_nxt;
      req_err   <= err_nxt;
      req_rdata <= rdata_nxt;
      spi_com   <= com_nxt;
      spi_addr  <= addr_nxt;
      mosi_data <= wdata_nxt;
      spi_run   <= run_nxt;
      busy      <= (state_nxt != S_IDLE);
    end
  end

endmodule
